// File: rtl/semafor_nway_ctrl.sv
// rtl/semafor_nway_ctrl.sv - N-approach round-robin intersection controller
// One green at a time, latched pedestrian requests, optional demand skipping and flashing-yellow service.
module semafor_nway_ctrl #(
    parameter int  N_APPR     = 4,
    parameter int  TICK_DIV   = 1000,
    parameter int  CW         = 8,
    parameter int  T_GREEN    = 20,
    parameter int  T_YELLOW   = 3,
    parameter int  T_ALLRED   = 2,
    parameter int  T_WALK     = 10,
    parameter int  T_PEDFLASH = 4,
    parameter int  SKIP_EMPTY = 0,
    localparam int IDX_W      = $clog2(N_APPR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_APPR-1:0] pietoni_btn_i,
    input  logic [N_APPR-1:0] veh_req_i,
    input  logic              service_i,
    output logic [N_APPR-1:0] verde_o,
    output logic [N_APPR-1:0] galben_o,
    output logic [N_APPR-1:0] rosu_o,
    output logic [N_APPR-1:0] verde_pietoni_o,
    output logic [N_APPR-1:0] rosu_pietoni_o,
    output logic [2:0]        phase_o,
    output logic [IDX_W-1:0]  approach_o
);
    localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_APPR - 1);

    typedef enum logic [2:0] {
        ST_ALL_RED   = 3'd0,
        ST_GREEN     = 3'd1,
        ST_YELLOW    = 3'd2,
        ST_PED_WALK  = 3'd3,
        ST_PED_FLASH = 3'd4,
        ST_SERVICE   = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  approach, approach_n, next_appr, cand;
    logic [CW-1:0]     timer, timer_load;
    logic [PW-1:0]     presc;
    logic              odd_tick;
    logic [N_APPR-1:0] pending, served, onehot;
    logic              srv_meta, srv_s;
    logic              tick, done, go;

    assign tick = (presc == PRESC_MAX);
    assign done = tick && (timer == '0);

    // Downward scan so the nearest approach after the current one wins; current one is checked last.
    always_comb begin
        next_appr = (approach == LAST) ? '0 : approach + 1'b1;
        cand      = '0;
        if (SKIP_EMPTY != 0) begin
            for (int k = N_APPR; k >= 1; k--) begin
                cand = IDX_W'((int'(approach) + k) % N_APPR);
                if (veh_req_i[cand]) next_appr = cand;
            end
        end
    end

    always_comb begin
        state_n    = state;
        approach_n = approach;
        go         = 1'b0;
        case (state)
            ST_ALL_RED: if (done) begin
                go = 1'b1;
                if (srv_s)         state_n = ST_SERVICE;
                else if (|pending) state_n = ST_PED_WALK;
                else begin
                    state_n    = ST_GREEN;
                    approach_n = next_appr;
                end
            end
            ST_GREEN: if (srv_s || done) begin
                go      = 1'b1;
                state_n = ST_YELLOW;
            end
            ST_YELLOW: if (done) begin
                go      = 1'b1;
                state_n = ST_ALL_RED;
            end
            ST_PED_WALK: if (srv_s || done) begin
                go      = 1'b1;
                state_n = ST_PED_FLASH;
            end
            ST_PED_FLASH: if (done) begin
                go = 1'b1;
                if (srv_s) state_n = ST_ALL_RED;
                else begin
                    state_n    = ST_GREEN;
                    approach_n = next_appr;
                end
            end
            ST_SERVICE: if (!srv_s) begin
                go         = 1'b1;
                state_n    = ST_ALL_RED;
                approach_n = LAST;
            end
            default: begin
                go      = 1'b1;
                state_n = ST_ALL_RED;
            end
        endcase
    end

    always_comb begin
        case (state_n)
            ST_GREEN:     timer_load = CW'(T_GREEN - 1);
            ST_YELLOW:    timer_load = CW'(T_YELLOW - 1);
            ST_ALL_RED:   timer_load = CW'(T_ALLRED - 1);
            ST_PED_WALK:  timer_load = CW'(T_WALK - 1);
            ST_PED_FLASH: timer_load = CW'(T_PEDFLASH - 1);
            default:      timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ALL_RED;
            approach <= LAST;
        end else begin
            state    <= state_n;
            approach <= approach_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            presc    <= '0;
            odd_tick <= 1'b0;
            pending  <= '0;
            served   <= '0;
            srv_meta <= 1'b0;
            srv_s    <= 1'b0;
        end else begin
            srv_meta <= service_i;
            srv_s    <= srv_meta;
            if (go) begin
                timer    <= timer_load;
                presc    <= '0;
                odd_tick <= 1'b0;
            end else if (tick) begin
                presc    <= '0;
                odd_tick <= ~odd_tick;
                if (timer != '0) timer <= timer - 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            // Presses already being served during the walk do not re-arm a request.
            if (state == ST_SERVICE) begin
                pending <= '0;
            end else if (state == ST_ALL_RED && state_n == ST_PED_WALK) begin
                served  <= pending | pietoni_btn_i;
                pending <= '0;
            end else if (state == ST_PED_WALK) begin
                pending <= pending | (pietoni_btn_i & ~served);
            end else begin
                pending <= pending | pietoni_btn_i;
            end
        end
    end

    always_comb begin
        onehot           = '0;
        onehot[approach] = 1'b1;
        verde_o          = '0;
        galben_o         = '0;
        rosu_o           = '1;
        verde_pietoni_o  = '0;
        case (state)
            ST_GREEN: begin
                verde_o = onehot;
                rosu_o  = ~onehot;
            end
            ST_YELLOW: begin
                galben_o = onehot;
                rosu_o   = ~onehot;
            end
            ST_PED_WALK:  verde_pietoni_o = served;
            ST_PED_FLASH: verde_pietoni_o = odd_tick ? '0 : served;
            ST_SERVICE: begin
                rosu_o   = '0;
                galben_o = odd_tick ? '0 : '1;
            end
            default: ;
        endcase
        rosu_pietoni_o = (state == ST_SERVICE) ? '0 : ~verde_pietoni_o;
    end

    assign phase_o    = state;
    assign approach_o = approach;
endmodule

// File: tb/tb_semafor_nway_ctrl.sv
// tb/tb_semafor_nway_ctrl.sv - randomized bench with cycle-level reference model for semafor_nway_ctrl
`timescale 1ns/1ps
module tb_semafor_nway_ctrl;
    localparam int N  = 4;
    localparam int TD = 2;
    localparam int P_AR = 0, P_GREEN = 1, P_YEL = 2, P_WALK = 3, P_FLASH = 4, P_SRV = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = '0;
    logic [3:0] veh = '0;
    logic       service = 1'b0;
    logic [3:0] verde[2], galben[2], rosu[2], vped[2], rped[2];
    logic [2:0] phase[2];
    logic [1:0] appr[2];

    always #5 clk = ~clk;

    semafor_nway_ctrl #(.N_APPR(4), .TICK_DIV(2), .CW(8), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1),
        .T_WALK(3), .T_PEDFLASH(2), .SKIP_EMPTY(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .pietoni_btn_i(btn), .veh_req_i(veh), .service_i(service),
        .verde_o(verde[0]), .galben_o(galben[0]), .rosu_o(rosu[0]), .verde_pietoni_o(vped[0]),
        .rosu_pietoni_o(rped[0]), .phase_o(phase[0]), .approach_o(appr[0]));

    semafor_nway_ctrl #(.N_APPR(4), .TICK_DIV(2), .CW(8), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1),
        .T_WALK(3), .T_PEDFLASH(2), .SKIP_EMPTY(1)) u_skip (
        .clk(clk), .rst_n(rst_n), .pietoni_btn_i(btn), .veh_req_i(veh), .service_i(service),
        .verde_o(verde[1]), .galben_o(galben[1]), .rosu_o(rosu[1]), .verde_pietoni_o(vped[1]),
        .rosu_pietoni_o(rped[1]), .phase_o(phase[1]), .approach_o(appr[1]));

    int checks = 0;
    int errors = 0;
    int j = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: phases measured in clock cycles, each lasting T*TD cycles.
    int         m_st[2], m_ap[2], m_cnt[2], m_dur[2];
    logic [3:0] m_pend[2], m_srvd[2];
    logic       q0, q1;

    function automatic int dur_of(input int st);
        case (st)
            P_GREEN: return 5 * TD;
            P_YEL:   return 2 * TD;
            P_AR:    return 1 * TD;
            P_WALK:  return 3 * TD;
            P_FLASH: return 2 * TD;
            default: return 1 << 30;
        endcase
    endfunction

    function automatic int nxt(input int a, input bit skip);
        if (skip)
            for (int k = 1; k <= N; k++)
                if (veh[(a + k) % N]) return (a + k) % N;
        return (a + 1) % N;
    endfunction

    task automatic model_step(input int i);
        int nst, nap;
        bit done, srv;
        srv  = q1;
        nst  = m_st[i];
        nap  = m_ap[i];
        done = (m_cnt[i] == m_dur[i] - 1);
        case (m_st[i])
            P_AR: if (done) begin
                if (srv) nst = P_SRV;
                else if (m_pend[i] != 0) nst = P_WALK;
                else begin nst = P_GREEN; nap = nxt(m_ap[i], i == 1); end
            end
            P_GREEN: if (srv || done) nst = P_YEL;
            P_YEL:   if (done) nst = P_AR;
            P_WALK:  if (srv || done) nst = P_FLASH;
            P_FLASH: if (done) begin
                if (srv) nst = P_AR;
                else begin nst = P_GREEN; nap = nxt(m_ap[i], i == 1); end
            end
            default: if (!srv) begin nst = P_AR; nap = N - 1; end
        endcase
        if (m_st[i] == P_SRV) m_pend[i] = 0;
        else if (m_st[i] == P_AR && nst == P_WALK) begin
            m_srvd[i] = m_pend[i] | btn;
            m_pend[i] = 0;
        end else if (m_st[i] == P_WALK) m_pend[i] = m_pend[i] | (btn & ~m_srvd[i]);
        else m_pend[i] = m_pend[i] | btn;
        if (nst != m_st[i]) begin m_cnt[i] = 0; m_dur[i] = dur_of(nst); end
        else m_cnt[i]++;
        m_st[i] = nst;
        m_ap[i] = nap;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = P_AR; m_ap[i] = N - 1; m_cnt[i] = 0; m_dur[i] = TD;
                m_pend[i] = 0; m_srvd[i] = 0;
            end
            q0 = 0; q1 = 0;
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
            q1 = q0;
            q0 = service;
        end
    end

    task automatic compare(input int i);
        logic [3:0] oh, ev, eg, er, evp, erp;
        bit odd;
        oh  = 4'b0001 << m_ap[i];
        odd = ((m_cnt[i] / TD) % 2) == 1;
        ev = 0; eg = 0; er = 4'hF; evp = 0;
        case (m_st[i])
            P_GREEN: begin ev = oh; er = ~oh; end
            P_YEL:   begin eg = oh; er = ~oh; end
            P_WALK:  evp = m_srvd[i];
            P_FLASH: evp = odd ? 4'h0 : m_srvd[i];
            P_SRV:   begin er = 0; eg = odd ? 4'h0 : 4'hF; end
            default: ;
        endcase
        erp = (m_st[i] == P_SRV) ? 4'h0 : ~evp;
        chk($sformatf("model_verde[%0d]", i), verde[i], ev);
        chk($sformatf("model_galben[%0d]", i), galben[i], eg);
        chk($sformatf("model_rosu[%0d]", i), rosu[i], er);
        chk($sformatf("model_vped[%0d]", i), vped[i], evp);
        chk($sformatf("model_rped[%0d]", i), rped[i], erp);
        chk($sformatf("model_phase[%0d]", i), phase[i], m_st[i]);
        chk($sformatf("model_appr[%0d]", i), appr[i], m_ap[i]);
    endtask

    always @(negedge clk) begin
        compare(0);
        compare(1);
    end

    task automatic step1;
        @(negedge clk);
        #1;
        j++;
    endtask

    task automatic go_to(input int k);
        while (j < k) step1();
    endtask

    task automatic do_reset;
        btn = 0; service = 0; rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rosu", rosu[i], 4'hF);
            chk("rst_rped", rped[i], 4'hF);
            chk("rst_vped", vped[i], 4'h0);
            chk("rst_verde", verde[i] | galben[i], 4'h0);
            chk("rst_phase", phase[i], P_AR);
            chk("rst_appr", appr[i], 3);
        end
        @(negedge clk);
        #1;
        rst_n = 1;
        j = 0;
    endtask

    int seen0[$], seen1[$];
    int prev0, prev1;
    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    int exp_skip[5];

    initial begin
        #1;
        // Sequence timing plus a pedestrian pulse during GREEN(0)
        do_reset();
        go_to(1);  chk("a_allred_hold", phase[0], P_AR);
        go_to(2);  chk("a_green0", verde[0], 4'b0001); chk("a_appr0", appr[0], 0);
        go_to(4);  btn = 4'b0100;
        go_to(5);  btn = 0;
        go_to(11); chk("a_green0_end", verde[0], 4'b0001);
        go_to(12); chk("a_yellow0", galben[0], 4'b0001);
        go_to(16); chk("a_allred", rosu[0], 4'hF);
        go_to(18); chk("a_walk_phase", phase[0], P_WALK); chk("a_walk", vped[0], 4'b0100);
                   chk("a_walk_rped", rped[0], 4'b1011);
        go_to(23); chk("a_walk_end", vped[0], 4'b0100);
        go_to(24); chk("a_flash_on", vped[0], 4'b0100); chk("a_flash_phase", phase[0], P_FLASH);
        go_to(26); chk("a_flash_off", vped[0], 4'b0000);
        go_to(28); chk("a_green1", verde[0], 4'b0010); chk("a_appr1", appr[0], 1);

        // Green order: round-robin vs demand skipping
        for (int p = 0; p < 2; p++) begin
            do_reset();
            veh = (p == 0) ? 4'b1001 : 4'b0000;
            exp_skip = (p == 0) ? '{0, 3, 0, 3, 0} : '{0, 1, 2, 3, 0};
            seen0.delete(); seen1.delete(); prev0 = P_AR; prev1 = P_AR;
            repeat (120) begin
                step1();
                if (phase[0] == P_GREEN && prev0 != P_GREEN) seen0.push_back(int'(appr[0]));
                if (phase[1] == P_GREEN && prev1 != P_GREEN) seen1.push_back(int'(appr[1]));
                prev0 = phase[0];
                prev1 = phase[1];
            end
            chk("b_green_count", (seen0.size() >= 5 && seen1.size() >= 5), 1);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("b_rr_green%0d", k), (k < seen0.size()) ? seen0[k] : -1, exp_rr[k]);
                chk($sformatf("b_skip_green%0d", k), (k < seen1.size()) ? seen1[k] : -1, exp_skip[k]);
            end
        end
        veh = 0;

        // Service mode entered from GREEN(1)
        do_reset();
        go_to(20); service = 1;
        go_to(22); chk("c_green_still", verde[0], 4'b0010);
        go_to(23); chk("c_yellow", galben[0], 4'b0010);
        go_to(27); chk("c_allred", phase[0], P_AR);
        go_to(29); chk("c_srv_on", galben[0], 4'hF); chk("c_srv_phase", phase[0], P_SRV);
                   chk("c_srv_rosu", rosu[0], 4'h0); chk("c_srv_rped", rped[0], 4'h0);
        go_to(31); chk("c_srv_off", galben[0], 4'h0);
        go_to(33); chk("c_srv_on2", galben[0], 4'hF);
        go_to(34); service = 0;
        go_to(36); chk("c_srv_hold", phase[0], P_SRV);
        go_to(37); chk("c_exit_allred", phase[0], P_AR); chk("c_exit_appr", appr[0], 3);
        go_to(39); chk("c_green0", verde[0], 4'b0001);

        // Presses during a walk, then reset mid-walk
        do_reset();
        go_to(4);  btn = 4'b0100;
        go_to(5);  btn = 0;
        go_to(18); btn = 4'b0100;
        go_to(19); btn = 4'b0101;
        go_to(20); btn = 4'b0100; chk("d_walk_served", vped[0], 4'b0100);
        go_to(22); btn = 0;
        go_to(44); chk("d_walk2_phase", phase[0], P_WALK); chk("d_walk2", vped[0], 4'b0001);
        go_to(45);
        do_reset();
        go_to(2);  chk("d_restart_green0", verde[0], 4'b0001);
        go_to(18); chk("d_no_pending", phase[0], P_GREEN); chk("d_green1", verde[0], 4'b0010);

        // Randomized traffic against the model
        do_reset();
        repeat (4000) begin
            step1();
            for (int b = 0; b < 4; b++) btn[b] = ($urandom_range(24) == 0);
            if ($urandom_range(149) == 0) service = ~service;
            if ($urandom_range(39) == 0) veh = 4'($urandom_range(15));
            if ($urandom_range(1999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
